// File: rtl/float64_mul_sig_stage.sv
// float64_mul_sig_stage: front half of the binary64 multiplier.
// Unpacks both operands, resolves NaN/Inf/zero, normalises subnormals and
// builds the sticky-folded significand product with a shift-add multiplier.
module float64_mul_sig_stage #(
   parameter int unsigned MUL_STEP = 4
) (
   input  logic        ap_clk,
   input  logic        ap_rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic [31:0] float_exception_flag_i,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_is_packed,
   output logic [63:0] out_packed,
   output logic        z_sign,
   output logic [12:0] z_exp,
   output logic [63:0] z_sig,
   output logic [31:0] float_exception_flag_o
);

   localparam int unsigned MUL_ITERS = 64 / MUL_STEP;
   localparam logic [31:0] FLAG_INVALID = 32'h0001_0000;

   typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_MUL, S_NORM, S_OUT} state_t;

   state_t        state_q;
   logic [63:0]   a_q, b_q;
   logic [31:0]   flag_q;
   logic [127:0]  mcand_q;
   logic [63:0]   mplier_q;
   logic [127:0]  acc_q;
   logic [12:0]   zexp_q;
   logic [6:0]    cnt_q;
   logic          in_ready_q, out_valid_q, out_is_packed_q, z_sign_q;
   logic [63:0]   out_packed_q, z_sig_q;
   logic [12:0]   z_exp_q;
   logic [31:0]   flag_o_q;

   // count of leading zeros in a 64-bit word (64 when zero)
   function automatic logic [6:0] clz64(input logic [63:0] v);
      logic [6:0] n;
      n = 7'd64;
      for (int unsigned i = 0; i < 64; i++)
         if (v[i]) n = 7'(63 - i);
      return n;
   endfunction

   logic [10:0]  a_exp, b_exp;
   logic [51:0]  a_sig, b_sig;
   logic         a_zero, b_zero, a_nan, b_nan, sign;
   logic         sp_special, sp_invalid;
   logic [63:0]  sp_packed;
   logic [6:0]   a_sh, b_sh;
   logic [52:0]  a_sig_n, b_sig_n;
   logic [12:0]  a_exp_n, b_exp_n, zexp_d;
   logic [127:0] mcand_d;
   logic [63:0]  mplier_d;

   // special-case resolution and operand normalisation on the latched operands
   always_comb begin
      a_exp  = a_q[62:52];
      b_exp  = b_q[62:52];
      a_sig  = a_q[51:0];
      b_sig  = b_q[51:0];
      sign   = a_q[63] ^ b_q[63];
      a_zero = (a_exp == '0) && (a_sig == '0);
      b_zero = (b_exp == '0) && (b_sig == '0);
      a_nan  = (a_exp == '1) && (a_sig != '0);
      b_nan  = (b_exp == '1) && (b_sig != '0);

      sp_special = 1'b0;
      sp_invalid = 1'b0;
      sp_packed  = '0;
      if (a_nan || b_nan) begin
         // any NaN operand wins over Inf/zero handling; quiet it and propagate
         sp_special = 1'b1;
         sp_invalid = (a_nan && !a_q[51]) || (b_nan && !b_q[51]);
         sp_packed  = b_nan ? (b_q | 64'h0008_0000_0000_0000)
                            : (a_q | 64'h0008_0000_0000_0000);
      end else if (a_exp == '1) begin
         sp_special = 1'b1;
         if (b_zero) begin
            sp_invalid = 1'b1;
            sp_packed  = 64'h7FFF_FFFF_FFFF_FFFF;
         end else begin
            sp_packed  = {sign, 11'h7FF, 52'd0};
         end
      end else if (b_exp == '1) begin
         sp_special = 1'b1;
         if (a_zero) begin
            sp_invalid = 1'b1;
            sp_packed  = 64'h7FFF_FFFF_FFFF_FFFF;
         end else begin
            sp_packed  = {sign, 11'h7FF, 52'd0};
         end
      end else if (a_zero || b_zero) begin
         sp_special = 1'b1;
         sp_packed  = {sign, 63'd0};
      end

      a_sh = clz64({12'd0, a_sig}) - 7'd11;
      b_sh = clz64({12'd0, b_sig}) - 7'd11;
      if (a_exp == '0) begin
         a_sig_n = {1'b0, a_sig} << a_sh;
         a_exp_n = 13'd1 - {6'd0, a_sh};
      end else begin
         a_sig_n = {1'b1, a_sig};
         a_exp_n = {2'd0, a_exp};
      end
      if (b_exp == '0) begin
         b_sig_n = {1'b0, b_sig} << b_sh;
         b_exp_n = 13'd1 - {6'd0, b_sh};
      end else begin
         b_sig_n = {1'b1, b_sig};
         b_exp_n = {2'd0, b_exp};
      end
      zexp_d   = a_exp_n + b_exp_n - 13'd1023;
      mcand_d  = {65'd0, a_sig_n, 10'd0};
      mplier_d = {b_sig_n, 11'd0};
   end

   logic [127:0] partial_d, acc_d;

   // one shift-add step: multiplicand times the low MUL_STEP multiplier bits
   always_comb begin
      partial_d = mcand_q * {{(128 - MUL_STEP){1'b0}}, mplier_q[MUL_STEP-1:0]};
      acc_d     = acc_q + partial_d;
   end

   logic [63:0] hi_d;
   logic [12:0] zexp_norm_d;

   // fold the low product half into a sticky bit and align the MSB to bit 62
   always_comb begin
      hi_d        = acc_q[127:64];
      hi_d[0]     = hi_d[0] | (acc_q[63:0] != '0);
      zexp_norm_d = zexp_q;
      if (!hi_d[62]) begin
         hi_d        = hi_d << 1;
         zexp_norm_d = zexp_q - 13'd1;
      end
   end

   // control FSM with registered handshake and result outputs
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q         <= S_IDLE;
         a_q             <= '0;
         b_q             <= '0;
         flag_q          <= '0;
         mcand_q         <= '0;
         mplier_q        <= '0;
         acc_q           <= '0;
         zexp_q          <= '0;
         cnt_q           <= '0;
         in_ready_q      <= 1'b1;
         out_valid_q     <= 1'b0;
         out_is_packed_q <= 1'b0;
         out_packed_q    <= '0;
         z_sign_q        <= 1'b0;
         z_exp_q         <= '0;
         z_sig_q         <= '0;
         flag_o_q        <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  a_q        <= a;
                  b_q        <= b;
                  flag_q     <= float_exception_flag_i;
                  in_ready_q <= 1'b0;
                  state_q    <= S_UNPACK;
               end
            end
            S_UNPACK: begin
               z_sign_q <= sign;
               if (sp_special) begin
                  out_is_packed_q <= 1'b1;
                  out_packed_q    <= sp_packed;
                  z_exp_q         <= '0;
                  z_sig_q         <= '0;
                  flag_o_q        <= flag_q | (sp_invalid ? FLAG_INVALID : '0);
                  out_valid_q     <= 1'b1;
                  state_q         <= S_OUT;
               end else begin
                  zexp_q   <= zexp_d;
                  mcand_q  <= mcand_d;
                  mplier_q <= mplier_d;
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  state_q  <= S_MUL;
               end
            end
            S_MUL: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << MUL_STEP;
               mplier_q <= mplier_q >> MUL_STEP;
               cnt_q    <= cnt_q + 7'd1;
               if (cnt_q == 7'(MUL_ITERS - 1)) state_q <= S_NORM;
            end
            S_NORM: begin
               z_sig_q         <= hi_d;
               z_exp_q         <= zexp_norm_d;
               out_is_packed_q <= 1'b0;
               out_packed_q    <= '0;
               flag_o_q        <= flag_q;
               out_valid_q     <= 1'b1;
               state_q         <= S_OUT;
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready               = in_ready_q;
   assign out_valid              = out_valid_q;
   assign out_is_packed          = out_is_packed_q;
   assign out_packed             = out_packed_q;
   assign z_sign                 = z_sign_q;
   assign z_exp                  = z_exp_q;
   assign z_sig                  = z_sig_q;
   assign float_exception_flag_o = flag_o_q;

endmodule

// File: tb/tb_float64_mul_sig_stage.sv
// Self-checking bench for float64_mul_sig_stage: directed vectors, random
// operands against a value-level reference model, handshake and reset cases,
// and a MUL_STEP sweep on parallel instances.
module tb_float64_mul_sig_stage;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [63:0] a, b;
   logic [31:0] flag_i, flag_o;
   logic        out_is_packed, z_sign;
   logic [63:0] out_packed, z_sig;
   logic [12:0] z_exp;

   int total = 0;
   int bad   = 0;

   always #5 ap_clk = ~ap_clk;

   float64_mul_sig_stage #(.MUL_STEP(4)) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .float_exception_flag_i(flag_i), .out_valid(out_valid),
      .out_ready(out_ready), .out_is_packed(out_is_packed), .out_packed(out_packed),
      .z_sign(z_sign), .z_exp(z_exp), .z_sig(z_sig), .float_exception_flag_o(flag_o)
   );

   // sweep instances with MUL_STEP = 1,2,4,8,16, downstream always ready
   logic        sw_in_valid;
   logic [63:0] sw_a, sw_b;
   logic        sw_in_ready [5];
   logic        sw_out_valid [5];
   logic        sw_is_packed [5];
   logic [63:0] sw_packed [5];
   logic        sw_sign [5];
   logic [12:0] sw_z_exp [5];
   logic [63:0] sw_z_sig [5];
   logic [31:0] sw_flag_o [5];

   for (genvar g = 0; g < 5; g++) begin : g_sw
      float64_mul_sig_stage #(.MUL_STEP(1 << g)) u_sw (
         .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(sw_in_valid),
         .in_ready(sw_in_ready[g]), .a(sw_a), .b(sw_b),
         .float_exception_flag_i(32'h0), .out_valid(sw_out_valid[g]),
         .out_ready(1'b1), .out_is_packed(sw_is_packed[g]), .out_packed(sw_packed[g]),
         .z_sign(sw_sign[g]), .z_exp(sw_z_exp[g]), .z_sig(sw_z_sig[g]),
         .float_exception_flag_o(sw_flag_o[g])
      );
   end

   // reference: float64_mul front half computed from operand values
   task automatic ref_mul(input logic [63:0] x, input logic [63:0] y, input logic [31:0] f,
                          output logic e_pk, output logic [63:0] e_packed,
                          output logic e_sign, output logic [12:0] e_zexp,
                          output logic [63:0] e_zsig, output logic [31:0] e_flag);
      logic [10:0]  ex, ey;
      logic [51:0]  fx, fy;
      logic         xnan, ynan, xinf, yinf, xzero, yzero, inv;
      logic [52:0]  mx, my;
      int           ix, iy, ze;
      logic [127:0] prod;
      logic [63:0]  hi;
      ex = x[62:52]; ey = y[62:52]; fx = x[51:0]; fy = y[51:0];
      xnan = (ex == 11'h7FF) && (fx != 0);  ynan = (ey == 11'h7FF) && (fy != 0);
      xinf = (ex == 11'h7FF) && (fx == 0);  yinf = (ey == 11'h7FF) && (fy == 0);
      xzero = (ex == 0) && (fx == 0);       yzero = (ey == 0) && (fy == 0);
      e_sign = x[63] ^ y[63];
      e_pk = 1'b1; e_packed = 64'h0; e_zexp = 13'h0; e_zsig = 64'h0; inv = 1'b0;
      if (xnan || ynan) begin
         inv = (xnan && !x[51]) || (ynan && !y[51]);
         e_packed = ynan ? (y | 64'h0008_0000_0000_0000) : (x | 64'h0008_0000_0000_0000);
      end else if ((xinf && yzero) || (yinf && xzero)) begin
         inv = 1'b1;
         e_packed = 64'h7FFF_FFFF_FFFF_FFFF;
      end else if (xinf || yinf) begin
         e_packed = {e_sign, 11'h7FF, 52'h0};
      end else if (xzero || yzero) begin
         e_packed = {e_sign, 63'h0};
      end else begin
         e_pk = 1'b0;
         mx = (ex == 0) ? {1'b0, fx} : {1'b1, fx};
         my = (ey == 0) ? {1'b0, fy} : {1'b1, fy};
         ix = (ex == 0) ? 1 : int'(ex);
         iy = (ey == 0) ? 1 : int'(ey);
         while (!mx[52]) begin mx = mx << 1; ix--; end
         while (!my[52]) begin my = my << 1; iy--; end
         ze = ix + iy - 1023;
         prod = {75'h0, mx} * {75'h0, my};
         hi = prod[106:43];
         hi[0] = hi[0] | (prod[42:0] != 0);
         if (!hi[62]) begin hi = hi << 1; ze--; end
         e_zexp = 13'(ze);
         e_zsig = hi;
      end
      e_flag = f | (inv ? 32'h0001_0000 : 32'h0);
   endtask

   // operand classes: 0 zero, 1 subnormal, 2 inf, 3 qNaN, 4 sNaN, else normal
   function automatic logic [63:0] rand_op(input int unsigned cls);
      logic [63:0] r;
      logic [51:0] s;
      logic        sg;
      logic [10:0] e;
      r = {$urandom, $urandom};
      s = r[51:0];
      sg = r[63];
      case (cls)
         0: return {sg, 63'h0};
         1: begin
            s = s >> $urandom_range(0, 51);
            if (s == 0) s = 52'h1;
            return {sg, 11'h0, s};
         end
         2: return {sg, 11'h7FF, 52'h0};
         3: return {sg, 11'h7FF, 1'b1, s[50:0]};
         4: begin
            if (s[50:0] == 0) s[0] = 1'b1;
            return {sg, 11'h7FF, 1'b0, s[50:0]};
         end
         default: begin
            e = 11'($urandom_range(1, 2046));
            return {sg, e, s};
         end
      endcase
   endfunction

   // drive one operation and wait (bounded) for out_valid; lat counts edges after accept
   task automatic run_op(input logic [63:0] opa, input logic [63:0] opb,
                         input logic [31:0] f, output int lat);
      int w;
      w = 0;
      @(negedge ap_clk);
      while (!in_ready && w < 200) begin @(negedge ap_clk); w++; end
      a = opa; b = opb; flag_i = f; in_valid = 1'b1;
      @(posedge ap_clk);
      @(negedge ap_clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge ap_clk); @(negedge ap_clk); lat++;
      end
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge ap_clk);
      @(negedge ap_clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      @(negedge ap_clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      total++; if ({out_is_packed, z_sign, out_packed, z_sig, z_exp, flag_o} !== '0) begin
         bad++; $display("FAIL reset_outputs: got packed=%h z_sig=%h z_exp=%h flag=%h want all 0",
                         out_packed, z_sig, z_exp, flag_o);
      end
      ap_rst_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [63:0] da [6] = '{64'h4000000000000000, 64'h3FF0000000000000, 64'h7FF0000000000000,
                              64'h7FF0000000000001, 64'h8000000000000000, 64'h0000000000000001};
      logic [63:0] db [6] = '{64'h4008000000000000, 64'h3FF0000000000000, 64'h0000000000000000,
                              64'h3FF0000000000000, 64'h4014000000000000, 64'h4000000000000000};
      logic        dpk [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [63:0] dval [6] = '{64'h6000000000000000, 64'h4000000000000000, 64'h7FFFFFFFFFFFFFFF,
                                64'h7FF8000000000001, 64'h8000000000000000, 64'h4000000000000000};
      logic [12:0] dze [6] = '{13'h400, 13'h3FE, 13'h0, 13'h0, 13'h0, 13'h1FCD};
      logic [31:0] dadd [6] = '{32'h0, 32'h0, 32'h10000, 32'h10000, 32'h0, 32'h0};
      int          dlat [6] = '{18, 18, 1, 1, 1, 18};
      logic [31:0] f;
      int lat;
      for (int i = 0; i < 6; i++) begin
         f = $urandom & 32'hFFFE_FFFF;
         run_op(da[i], db[i], f, lat);
         total++; if (lat !== dlat[i]) begin bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, dlat[i]); end
         total++; if (out_is_packed !== dpk[i]) begin bad++; $display("FAIL dir%0d_is_packed: got %b want %b", i, out_is_packed, dpk[i]); end
         if (dpk[i]) begin
            total++; if (out_packed !== dval[i]) begin bad++; $display("FAIL dir%0d_packed: got %h want %h", i, out_packed, dval[i]); end
         end else begin
            total++; if (z_sig !== dval[i]) begin bad++; $display("FAIL dir%0d_z_sig: got %h want %h", i, z_sig, dval[i]); end
            total++; if (z_exp !== dze[i]) begin bad++; $display("FAIL dir%0d_z_exp: got %h want %h", i, z_exp, dze[i]); end
            total++; if (z_sign !== 1'b0) begin bad++; $display("FAIL dir%0d_z_sign: got %b want 0", i, z_sign); end
         end
         total++; if (flag_o !== (f | dadd[i])) begin bad++; $display("FAIL dir%0d_flags: got %h want %h", i, flag_o, f | dadd[i]); end
         release_out();
      end
   endtask

   task automatic test_random();
      logic [63:0] x, y, e_packed, e_zsig;
      logic [31:0] f, e_flag;
      logic        e_pk, e_sign;
      logic [12:0] e_zexp;
      int unsigned c;
      int lat;
      for (int i = 0; i < 40; i++) begin
         c = $urandom_range(0, 9); x = rand_op(c);
         c = $urandom_range(0, 9); y = rand_op(c);
         f = $urandom;
         ref_mul(x, y, f, e_pk, e_packed, e_sign, e_zexp, e_zsig, e_flag);
         run_op(x, y, f, lat);
         total++; if (lat !== (e_pk ? 1 : 18)) begin bad++; $display("FAIL rnd_latency a=%h b=%h: got %0d want %0d", x, y, lat, e_pk ? 1 : 18); end
         total++; if (out_is_packed !== e_pk) begin bad++; $display("FAIL rnd_is_packed a=%h b=%h: got %b want %b", x, y, out_is_packed, e_pk); end
         if (e_pk) begin
            total++; if (out_packed !== e_packed) begin bad++; $display("FAIL rnd_packed a=%h b=%h: got %h want %h", x, y, out_packed, e_packed); end
         end else begin
            total++; if ({z_sign, z_exp, z_sig} !== {e_sign, e_zexp, e_zsig}) begin
               bad++; $display("FAIL rnd_triple a=%h b=%h: got %b %h %h want %b %h %h", x, y, z_sign, z_exp, z_sig, e_sign, e_zexp, e_zsig);
            end
         end
         total++; if (flag_o !== e_flag) begin bad++; $display("FAIL rnd_flags a=%h b=%h: got %h want %h", x, y, flag_o, e_flag); end
         release_out();
      end
   endtask

   task automatic test_hold();
      logic [63:0] x, y, e_packed, e_zsig;
      logic [31:0] f, e_flag;
      logic        e_pk, e_sign;
      logic [12:0] e_zexp;
      int lat;
      x = rand_op(5); y = rand_op(5); f = $urandom;
      ref_mul(x, y, f, e_pk, e_packed, e_sign, e_zexp, e_zsig, e_flag);
      run_op(x, y, f, lat);
      total++; if ({z_sign, z_exp, z_sig} !== {e_sign, e_zexp, e_zsig}) begin
         bad++; $display("FAIL hold_result: got %b %h %h want %b %h %h", z_sign, z_exp, z_sig, e_sign, e_zexp, e_zsig);
      end
      // a competing request while OUT is stalled must be ignored
      a = ~x; b = ~y; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge ap_clk); @(negedge ap_clk);
         total++; if ({out_valid, in_ready} !== 2'b10) begin bad++; $display("FAIL hold_handshake cyc%0d: got valid=%b ready=%b want 1 0", i, out_valid, in_ready); end
         total++; if ({z_exp, z_sig, flag_o} !== {e_zexp, e_zsig, e_flag}) begin
            bad++; $display("FAIL hold_stable cyc%0d: got %h %h %h want %h %h %h", i, z_exp, z_sig, flag_o, e_zexp, e_zsig, e_flag);
         end
      end
      in_valid = 1'b0;
      release_out();
      total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL hold_release: got valid=%b ready=%b want 0 1", out_valid, in_ready); end
   endtask

   task automatic test_reset_mid();
      logic [63:0] x, y, e_packed, e_zsig;
      logic [31:0] f, e_flag;
      logic        e_pk, e_sign;
      logic [12:0] e_zexp;
      int lat, seen;
      @(negedge ap_clk);
      a = 64'h4000000000000000; b = 64'h4008000000000000; flag_i = 32'h0; in_valid = 1'b1;
      @(posedge ap_clk); @(negedge ap_clk);
      in_valid = 1'b0;
      repeat (5) begin @(posedge ap_clk); @(negedge ap_clk); end
      #2 ap_rst_n = 1'b0;
      #1;
      total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL rstmid_handshake: got valid=%b ready=%b want 0 1", out_valid, in_ready); end
      total++; if ({z_sig, z_exp, flag_o} !== '0) begin bad++; $display("FAIL rstmid_outputs: got %h %h %h want 0", z_sig, z_exp, flag_o); end
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      seen = 0;
      repeat (30) begin @(posedge ap_clk); @(negedge ap_clk); if (out_valid) seen++; end
      total++; if (seen !== 0) begin bad++; $display("FAIL rstmid_no_emit: got %0d valid cycles want 0", seen); end
      x = rand_op(5); y = rand_op(1); f = $urandom;
      ref_mul(x, y, f, e_pk, e_packed, e_sign, e_zexp, e_zsig, e_flag);
      run_op(x, y, f, lat);
      total++; if ({out_is_packed, z_sign, z_exp, z_sig, flag_o} !== {e_pk, e_sign, e_zexp, e_zsig, e_flag}) begin
         bad++; $display("FAIL rstmid_after: got %b %h %h want %b %h %h", out_is_packed, z_exp, z_sig, e_pk, e_zexp, e_zsig);
      end
      release_out();
   endtask

   task automatic test_back_to_back();
      logic [63:0] x, y, e_packed, e_zsig;
      logic [31:0] f, e_flag;
      logic        e_pk, e_sign;
      logic [12:0] e_zexp;
      logic [63:0] q_val [$];
      logic [31:0] q_flag [$];
      logic        q_pk [$];
      logic [63:0] ev;
      int sent, done;
      sent = 0; done = 0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 400 && done < 6; cyc++) begin
         @(negedge ap_clk);
         if (out_valid) begin
            if (q_val.size() == 0) begin
               total++; bad++; $display("FAIL b2b_unexpected: got extra out_valid want none");
            end else begin
               ev = q_val.pop_front();
               total++; if ((out_is_packed ? out_packed : z_sig) !== ev || out_is_packed !== q_pk[0] || flag_o !== q_flag[0]) begin
                  bad++; $display("FAIL b2b_result%0d: got %h flag %h want %h flag %h", done, out_is_packed ? out_packed : z_sig, flag_o, ev, q_flag[0]);
               end
               void'(q_pk.pop_front()); void'(q_flag.pop_front());
               done++;
            end
         end
         in_valid = 1'b0;
         if (in_ready && sent < 6) begin
            x = rand_op((sent % 3 == 1) ? 2 : 5); y = rand_op(5); f = $urandom;
            ref_mul(x, y, f, e_pk, e_packed, e_sign, e_zexp, e_zsig, e_flag);
            a = x; b = y; flag_i = f; in_valid = 1'b1;
            q_val.push_back(e_pk ? e_packed : e_zsig); q_pk.push_back(e_pk); q_flag.push_back(e_flag);
            sent++;
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      total++; if (done !== 6) begin bad++; $display("FAIL b2b_count: got %0d results want 6", done); end
   endtask

   task automatic test_step_sweep();
      logic [63:0] x, y, e_packed, e_zsig;
      logic [31:0] e_flag;
      logic        e_pk, e_sign;
      logic [12:0] e_zexp;
      int first [5];
      logic [63:0] got_sig [5];
      logic [12:0] got_exp [5];
      for (int n = 0; n < 3; n++) begin
         x = rand_op(($urandom_range(0, 3) == 0) ? 1 : 5);
         y = rand_op(5);
         ref_mul(x, y, 32'h0, e_pk, e_packed, e_sign, e_zexp, e_zsig, e_flag);
         for (int g = 0; g < 5; g++) first[g] = -1;
         @(negedge ap_clk);
         sw_a = x; sw_b = y; sw_in_valid = 1'b1;
         @(posedge ap_clk); @(negedge ap_clk);
         sw_in_valid = 1'b0;
         for (int cyc = 1; cyc <= 80; cyc++) begin
            @(posedge ap_clk); @(negedge ap_clk);
            for (int g = 0; g < 5; g++)
               if (sw_out_valid[g] && first[g] < 0) begin
                  first[g] = cyc; got_sig[g] = sw_z_sig[g]; got_exp[g] = sw_z_exp[g];
               end
         end
         for (int g = 0; g < 5; g++) begin
            total++; if (first[g] !== 2 + (64 >> g)) begin bad++; $display("FAIL sweep_step%0d_latency: got %0d want %0d", 1 << g, first[g], 2 + (64 >> g)); end
            total++; if ({got_exp[g], got_sig[g]} !== {e_zexp, e_zsig}) begin
               bad++; $display("FAIL sweep_step%0d_result a=%h b=%h: got %h %h want %h %h", 1 << g, x, y, got_exp[g], got_sig[g], e_zexp, e_zsig);
            end
         end
      end
   endtask

   initial begin
      ap_rst_n = 1'b0;
      in_valid = 1'b0; a = '0; b = '0; flag_i = '0; out_ready = 1'b0;
      sw_in_valid = 1'b0; sw_a = '0; sw_b = '0;
      test_reset();
      test_directed();
      test_random();
      test_hold();
      test_reset_mid();
      test_back_to_back();
      test_step_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
